// File: rtl/tmds_lane_gearbox.sv
// tmds_lane_gearbox: multi-lane TMDS word serializer gearbox in the fast clock domain.
// Accepts NUM_CH words per pixel over valid/ready and emits OUT_W bits per lane per
// cycle, LSB first, together with the matching clock-lane pattern. If no word is
// available at a word boundary, IDLE_WORD is sent on every lane and underflow pulses.
// Optional feature macro: TMDS_GEARBOX_UFCNT_EN enables the saturating underflow counter.
module tmds_lane_gearbox #(
  parameter int                NUM_CH    = 3,
  parameter int                WORD_W    = 10,
  parameter int                OUT_W     = 2,
  parameter logic [WORD_W-1:0] IDLE_WORD = 10'b1101010100,
  parameter logic [WORD_W-1:0] CLK_WORD  = 10'b0000011111
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*WORD_W-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [NUM_CH*OUT_W-1:0]  dout,
  output logic [OUT_W-1:0]         clk_lane,
  output logic                     word_start,
  output logic                     underflow,
  output logic [15:0]              underflow_cnt
);

  localparam int              R       = WORD_W / OUT_W;
  localparam int              PH_W    = (R > 1) ? $clog2(R) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(R - 1);

  logic [PH_W-1:0]                r_phase;
  logic [NUM_CH*WORD_W-1:0]       r_buf;
  logic                           r_buf_valid;
  logic [NUM_CH-1:0][WORD_W-1:0]  r_sh;
  logic [WORD_W-1:0]              r_shc;
  logic                           r_underflow;

  logic w_load;
  logic w_hs;

  // The last phase of a word is the load cycle; the buffer can only refill then or when empty.
  assign w_load  = (r_phase == PH_LAST);
  assign s_ready = ~r_buf_valid | w_load;
  assign w_hs    = s_valid & s_ready;

  // Phase counter, shift registers, buffer occupancy and underflow flag.
  // NOTE: every sequential assignment is non-blocking so all registers sample
  // pre-edge values, no matter the order statements appear in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase     <= '0;
      r_buf_valid <= 1'b0;
      r_underflow <= 1'b0;
      r_sh        <= '0;
      r_shc       <= '0;
    end else if (w_load) begin
      r_phase     <= '0;
      r_shc       <= CLK_WORD;
      r_underflow <= 1'b0;
      if (r_buf_valid) begin
        // Buffered word goes out; a simultaneous handshake refills the buffer.
        r_sh        <= r_buf;
        r_buf_valid <= w_hs;
      end else if (w_hs) begin
        // Empty buffer: the arriving word bypasses straight into the shifters.
        r_sh <= s_data;
      end else begin
        r_sh        <= {NUM_CH{IDLE_WORD}};
        r_underflow <= 1'b1;
      end
    end else begin
      r_phase     <= r_phase + PH_W'(1);
      r_shc       <= r_shc >> OUT_W;
      r_underflow <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_sh[i] <= r_sh[i] >> OUT_W;
      end
      if (w_hs) begin
        r_buf_valid <= 1'b1;
      end
    end
  end

  // Holding buffer data: captured on every handshake that does not bypass.
  // NOTE: data-only register with no reset; r_buf_valid qualifies its contents.
  always_ff @(posedge clk) begin
    if (w_hs && (r_buf_valid || !w_load)) begin
      r_buf <= s_data;
    end
  end

  // Each lane drives the low OUT_W bits of its shifter.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    assign dout[g*OUT_W +: OUT_W] = r_sh[g][OUT_W-1:0];
  end

  assign clk_lane   = r_shc[OUT_W-1:0];
  assign word_start = (r_phase == '0);
  assign underflow  = r_underflow;

`ifdef TMDS_GEARBOX_UFCNT_EN
  logic [15:0] r_ufcnt;

  // Saturating count of underflow pulses; cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ufcnt <= '0;
    end else if (r_underflow && (r_ufcnt != 16'hFFFF)) begin
      r_ufcnt <= r_ufcnt + 16'd1;
    end
  end

  assign underflow_cnt = r_ufcnt;
`else
  assign underflow_cnt = 16'h0000;
`endif

endmodule
